// File: rtl/rle_video_pkg.sv
// rtl/rle_video_pkg.sv - shared types and defaults for the RLE video prefetch path
package rle_video_pkg;

    localparam int RLE_DATA_WIDTH = 16;
    localparam int RLE_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT_BUSY,
        FETCH_WAIT_DATA
    } fetch_state_e;

endpackage

// File: rtl/prefetch_ram.sv
// rtl/prefetch_ram.sv - DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read
module prefetch_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    // Contents are deliberately not reset; validity is tracked by the level counter.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rle_prefetch_fifo.sv
// rtl/rle_prefetch_fifo.sv - flash word prefetcher: keeps a small FIFO topped up
// with one outstanding read at a time, flushed by stop.
module rle_prefetch_fifo
    import rle_video_pkg::*;
#(
    parameter int DATA_WIDTH = RLE_DATA_WIDTH,
    parameter int DEPTH      = RLE_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic                       stop,
    output logic                       spi_start_read,
    output logic                       spi_continue_read,
    output logic                       spi_stop_read,
    input  logic                       spi_busy,
    input  logic [DATA_WIDTH-1:0]      spi_data,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    fetch_state_e     state_q;
    logic             first_req_q;
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             start_rd_q;
    logic             cont_rd_q;
    logic             stop_rd_q;

    logic             pop;
    logic             push;
    logic             can_req;

    assign pop     = (level_q != '0) && out_ready;
    assign push    = (state_q == FETCH_WAIT_DATA) && !spi_busy && !stop;
    // A slot freed by this cycle's pop is enough to issue the next read.
    assign can_req = (level_q - LVL_W'(pop)) < LVL_W'(DEPTH);

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= FETCH_IDLE;
            first_req_q <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            start_rd_q  <= 1'b0;
            cont_rd_q   <= 1'b0;
            stop_rd_q   <= 1'b0;
        end else begin
            start_rd_q <= 1'b0;
            cont_rd_q  <= 1'b0;
            stop_rd_q  <= 1'b0;
            if (stop) begin
                state_q     <= FETCH_IDLE;
                first_req_q <= 1'b0;
                wptr_q      <= '0;
                rptr_q      <= '0;
                level_q     <= '0;
                stop_rd_q   <= 1'b1;
            end else begin
                if (push) begin
                    wptr_q <= wptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rptr_q <= rptr_q + PTR_W'(1);
                end
                level_q <= level_d;
                case (state_q)
                    FETCH_IDLE: begin
                        if (start) begin
                            state_q     <= FETCH_REQ;
                            first_req_q <= 1'b1;
                        end
                    end
                    FETCH_REQ: begin
                        if (can_req) begin
                            start_rd_q  <= first_req_q;
                            cont_rd_q   <= !first_req_q;
                            first_req_q <= 1'b0;
                            state_q     <= FETCH_WAIT_BUSY;
                        end
                    end
                    FETCH_WAIT_BUSY: begin
                        if (spi_busy) begin
                            state_q <= FETCH_WAIT_DATA;
                        end
                    end
                    FETCH_WAIT_DATA: begin
                        if (!spi_busy) begin
                            state_q <= FETCH_REQ;
                        end
                    end
                    default: state_q <= FETCH_IDLE;
                endcase
            end
        end
    end

    prefetch_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i (spi_data),
        .raddr_i (rptr_q),
        .rdata_o (out_data)
    );

    assign out_valid         = (level_q != '0);
    assign level             = level_q;
    assign spi_start_read    = start_rd_q;
    assign spi_continue_read = cont_rd_q;
    assign spi_stop_read     = stop_rd_q;

endmodule

// File: tb/tb_rle_prefetch_fifo.sv
// tb/tb_rle_prefetch_fifo.sv - randomized and directed bench for rle_prefetch_fifo
module tb_rle_prefetch_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rstn;
    logic          start;
    logic          stop;
    logic          spi_start_read;
    logic          spi_continue_read;
    logic          spi_stop_read;
    logic          spi_busy;
    logic [DW-1:0] spi_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [$clog2(DEPTH):0] level;

    rle_prefetch_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .start             (start),
        .stop              (stop),
        .spi_start_read    (spi_start_read),
        .spi_continue_read (spi_continue_read),
        .spi_stop_read     (spi_stop_read),
        .spi_busy          (spi_busy),
        .spi_data          (spi_data),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .level             (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: the FIFO is just the ordered list of words delivered while streaming.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] word_src[$];
    bit            active;
    bit            expect_first;
    bit            outstanding;
    bit            deliver;
    bit            stop_pending;
    bit            rand_busy;
    int            busy_cyc;
    int            ctl_cnt;
    logic [DW-1:0] ctl_word;
    int            stall_cnt;
    int            n_start;
    int            n_cont;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        mq.delete();
        active       = 0;
        expect_first = 0;
        outstanding  = 0;
        deliver      = 0;
        stop_pending = 0;
        ctl_cnt      = 0;
        stall_cnt    = 0;
        spi_busy     = 1'b0;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        #1;
        check("rst_level", 32'(level), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_start_rd", 32'(spi_start_read), 0);
        check("rst_cont_rd", 32'(spi_continue_read), 0);
        check("rst_stop_rd", 32'(spi_stop_read), 0);
        clear_model();
        start     = 1'b0;
        stop      = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Called at a negedge: applies one clock of stimulus, then checks and runs the flash model.
    task automatic step(input logic st, input logic sp, input logic rdy);
        if (sp) begin
            mq.delete();
            active       = 0;
            expect_first = 0;
        end else begin
            if (mq.size() != 0 && rdy) mq.delete(0);
            if (deliver) mq.push_back(ctl_word);
            if (st && !active) begin
                active       = 1;
                expect_first = 1;
            end
        end
        stop_pending = sp;
        start     = st;
        stop      = sp;
        out_ready = rdy;
        @(negedge clk);
        start     = 1'b0;
        stop      = 1'b0;
        out_ready = 1'b0;
        deliver   = 0;

        check("level", 32'(level), 32'(mq.size()));
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check("out_data", 32'(out_data), 32'(mq[0]));
        check("stop_read", 32'(spi_stop_read), 32'(stop_pending));
        check("pulse_excl",
              32'((32'(spi_start_read) + 32'(spi_continue_read) + 32'(spi_stop_read)) <= 1), 1);

        if (spi_stop_read) begin
            ctl_cnt     = 0;
            spi_busy    = 1'b0;
            outstanding = 0;
        end else if (spi_start_read || spi_continue_read) begin
            check("req_kind", 32'(spi_start_read), 32'(expect_first));
            check("req_overlap", 32'(outstanding), 0);
            check("req_room", 32'(mq.size() < DEPTH), 1);
            n_start     += int'(spi_start_read);
            n_cont      += int'(spi_continue_read);
            expect_first = 0;
            outstanding  = 1;
            if (rand_busy) busy_cyc = $urandom_range(1, 4);
            ctl_cnt  = busy_cyc;
            ctl_word = (word_src.size() != 0) ? word_src.pop_front() : DW'($urandom);
            spi_busy = 1'b1;
            spi_data = DW'($urandom);
        end else if (ctl_cnt > 0) begin
            ctl_cnt--;
            if (ctl_cnt == 0) begin
                spi_busy    = 1'b0;
                spi_data    = ctl_word;
                deliver     = 1;
                outstanding = 0;
            end
        end

        if (active && !outstanding && mq.size() < DEPTH) stall_cnt++;
        else stall_cnt = 0;
        check("no_stall", 32'(stall_cnt > 3), 0);
    endtask

    int            guard;
    int            pairs;
    int            vcnt;
    int            ns;
    logic [DW-1:0] seen;
    bit            both;

    initial begin
        rstn      = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        out_ready = 1'b0;
        spi_busy  = 1'b0;
        spi_data  = '0;
        rand_busy = 0;
        busy_cyc  = 3;
        n_start   = 0;
        n_cont    = 0;
        clear_model();
        #2;
        apply_reset();

        // Fill with no consumer: four reads, then nothing more.
        word_src = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        step(1, 0, 0);
        repeat (40) step(0, 0, 0);
        check("fill_level", 32'(level), 4);
        check("fill_starts", 32'(n_start), 1);
        check("fill_conts", 32'(n_cont), 3);

        // One pop from full frees a slot; refill request follows next cycle.
        check("full_head", 32'(out_data), 32'h1111);
        step(0, 0, 1);
        check("pop_head", 32'(out_data), 32'h2222);
        check("pop_refill", 32'(spi_continue_read), 1);
        step(0, 1, 0);
        step(0, 0, 0);

        // Pass-through with consumer always ready.
        word_src = '{16'hABCD};
        vcnt = 0;
        seen = '0;
        step(1, 0, 1);
        repeat (9) begin
            step(0, 0, 1);
            if (out_valid) begin
                vcnt++;
                seen = out_data;
            end
        end
        check("pass_valid_cycles", 32'(vcnt), 1);
        check("pass_word", 32'(seen), 32'hABCD);
        check("pass_level", 32'(level), 0);
        step(0, 1, 0);
        step(0, 0, 0);

        // Stop while a word is landing: the word must be dropped.
        word_src = '{16'h1111, 16'h2222, 16'h5555};
        step(1, 0, 0);
        guard = 0;
        while (!(deliver && ctl_word == 16'h5555) && guard < 100) begin
            step(0, 0, 0);
            guard++;
        end
        check("late_reached", 32'(guard < 100), 1);
        check("late_level2", 32'(level), 2);
        step(0, 1, 0);
        check("late_stop_pulse", 32'(spi_stop_read), 1);
        check("late_level0", 32'(level), 0);
        check("late_valid0", 32'(out_valid), 0);
        repeat (6) step(0, 0, 0);
        check("late_still_empty", 32'(level), 0);
        ns = n_start;
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        check("late_restart", 32'(n_start), 32'(ns + 1));
        step(0, 1, 0);
        step(0, 0, 0);

        // Steady state at level 3 with push and pop together, across pointer wrap.
        for (int i = 0; i < 14; i++) word_src.push_back(DW'(16'h0A00 + i));
        pairs = 0;
        guard = 0;
        step(1, 0, 0);
        while (pairs < 10 && guard < 400) begin
            both = deliver && (mq.size() >= 3);
            step(0, 0, both);
            if (both) begin
                pairs++;
                check("pp_level", 32'(level), 3);
            end
            guard++;
        end
        check("pp_pairs", 32'(pairs), 10);
        step(0, 1, 0);
        step(0, 0, 0);
        word_src.delete();

        // Asynchronous reset while waiting on the flash.
        step(1, 0, 0);
        guard = 0;
        while (!(spi_start_read || spi_continue_read) && guard < 20) begin
            step(0, 0, 0);
            guard++;
        end
        check("rst_busy_reached", 32'(guard < 20), 1);
        #2;
        apply_reset();
        ns = n_start;
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        check("rst_restart", 32'(n_start), 32'(ns + 1));

        // Random traffic.
        rand_busy = 1;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 1) == 0));
            if ($urandom_range(0, 999) == 0) begin
                #2;
                apply_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
